// File: rtl/gpio_input_conditioner_pkg.sv
// Constants shared between the GPIO input conditioner and the rvx GPIO block.
package gpio_input_conditioner_pkg;

    localparam int unsigned GPIO_WIDTH_DEFAULT   = 3;
    localparam int unsigned CLOCK_FREQUENCY      = 12_000_000;
    localparam int unsigned TICK_DIVIDER_DEFAULT = CLOCK_FREQUENCY / 1000;
    localparam int unsigned STABLE_COUNT_DEFAULT = 8;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned ctr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpio_debounce_channel.sv
// One pad: two-flop synchroniser, tick-driven stability filter and debounced edge pulses.
module gpio_debounce_channel
    import gpio_input_conditioner_pkg::*;
#(
    parameter int unsigned STABLE_COUNT = STABLE_COUNT_DEFAULT
) (
    input  logic clock,
    input  logic reset_n,
    input  logic tick,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = $clog2(STABLE_COUNT + 1);

    logic          meta_q, meta_d;
    logic          sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    always_comb begin
        meta_d   = raw;
        sync_d   = meta_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (tick) begin
            if (sync_q == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(STABLE_COUNT - 1)) begin
                stable_d = sync_q;
                cnt_d    = '0;
                rise_d   = sync_q;
                fall_d   = ~sync_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Edge pulses are registered so they line up with the cycle the new stable value is visible.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            meta_q   <= meta_d;
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign stable = stable_q;
    assign rise   = rise_q;
    assign fall   = fall_q;

endmodule

// File: rtl/gpio_input_conditioner.sv
// Conditions raw GPIO pads for rvx: shared sample prescaler, per-pin debounce, oe loopback,
// sticky edge-pending register and level irq.
module gpio_input_conditioner
    import gpio_input_conditioner_pkg::*;
#(
    parameter int unsigned GPIO_WIDTH   = GPIO_WIDTH_DEFAULT,
    parameter int unsigned TICK_DIVIDER = TICK_DIVIDER_DEFAULT,
    parameter int unsigned STABLE_COUNT = STABLE_COUNT_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [GPIO_WIDTH-1:0] gpio_raw,
    input  logic [GPIO_WIDTH-1:0] gpio_oe,
    input  logic [GPIO_WIDTH-1:0] gpio_output,
    output logic [GPIO_WIDTH-1:0] gpio_input,
    input  logic [GPIO_WIDTH-1:0] rise_enable,
    input  logic [GPIO_WIDTH-1:0] fall_enable,
    input  logic [GPIO_WIDTH-1:0] pending_clear,
    output logic [GPIO_WIDTH-1:0] pending,
    output logic                  irq
);

    localparam int unsigned PW = ctr_width(TICK_DIVIDER);

    logic [PW-1:0]         presc_q, presc_d;
    logic                  tick;
    logic [GPIO_WIDTH-1:0] stable, rise, fall;
    logic [GPIO_WIDTH-1:0] pending_q, pending_d;

    assign tick = (presc_q == PW'(TICK_DIVIDER - 1));

    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_chan
        gpio_debounce_channel #(
            .STABLE_COUNT(STABLE_COUNT)
        ) u_chan (
            .clock  (clock),
            .reset_n(reset_n),
            .tick   (tick),
            .raw    (gpio_raw[i]),
            .stable (stable[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

    // Events on pins driven as outputs are dropped; a new event beats a simultaneous clear.
    always_comb begin
        pending_d = (pending_q & ~pending_clear)
                  | (rise & rise_enable & ~gpio_oe)
                  | (fall & fall_enable & ~gpio_oe);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc_q   <= '0;
            pending_q <= '0;
        end else begin
            presc_q   <= presc_d;
            pending_q <= pending_d;
        end
    end

    assign gpio_input = (gpio_oe & gpio_output) | (~gpio_oe & stable);
    assign pending    = pending_q;
    assign irq        = |pending_q;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Bench for gpio_input_conditioner: directed scenarios plus random stimulus against a cycle model.
module tb_gpio_input_conditioner;

    localparam int unsigned W  = 3;
    localparam int unsigned TD = 4;
    localparam int unsigned SC = 3;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [W-1:0] gpio_raw, gpio_oe, gpio_output, gpio_input;
    logic [W-1:0] rise_enable, fall_enable, pending_clear, pending;
    logic         irq;

    gpio_input_conditioner #(
        .GPIO_WIDTH  (W),
        .TICK_DIVIDER(TD),
        .STABLE_COUNT(SC)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .gpio_raw     (gpio_raw),
        .gpio_oe      (gpio_oe),
        .gpio_output  (gpio_output),
        .gpio_input   (gpio_input),
        .rise_enable  (rise_enable),
        .fall_enable  (fall_enable),
        .pending_clear(pending_clear),
        .pending      (pending),
        .irq          (irq)
    );

    always #5 clock = ~clock;

    // Stimulus held by the bench, applied on each falling edge.
    logic         rst_v;
    logic [W-1:0] raw_v, oe_v, out_v, ren_v, fen_v, clr_v;

    // Model: state as seen by the outputs in the current cycle.
    logic [W-1:0] m_h1, m_h2;        // raw one and two clock edges ago
    logic [W-1:0] m_stable, m_rise, m_fall, m_pend;
    int unsigned  m_run [W];         // consecutive sample ticks disagreeing with stable
    int unsigned  m_ncyc;            // clock edges since reset release

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_h1 = '0; m_h2 = '0; m_stable = '0; m_rise = '0; m_fall = '0; m_pend = '0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
        m_ncyc = 0;
    endtask

    task automatic model_edge();
        logic         tick;
        logic [W-1:0] nr, nf;
        if (!rst_v) return;
        tick = ((m_ncyc % TD) == TD - 1);
        nr = '0; nf = '0;
        m_pend = (m_pend & ~clr_v) | (m_rise & ~oe_v & ren_v) | (m_fall & ~oe_v & fen_v);
        for (int i = 0; i < W; i++) begin
            if (tick) begin
                if (m_h2[i] != m_stable[i]) begin
                    m_run[i]++;
                    if (m_run[i] == SC) begin
                        m_stable[i] = m_h2[i];
                        nr[i] = m_h2[i];
                        nf[i] = ~m_h2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
        m_rise = nr;
        m_fall = nf;
        m_h2 = m_h1;
        m_h1 = raw_v;
        m_ncyc++;
    endtask

    task automatic compare();
        check("gpio_input", gpio_input, (oe_v & out_v) | (~oe_v & m_stable));
        check("pending", pending, m_pend);
        check("irq", {{(W-1){1'b0}}, irq}, {{(W-1){1'b0}}, |m_pend});
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            reset_n = rst_v; gpio_raw = raw_v; gpio_oe = oe_v; gpio_output = out_v;
            rise_enable = ren_v; fall_enable = fen_v; pending_clear = clr_v;
            if (!rst_v) model_reset();
            #1;
            compare();
            model_edge();
        end
    endtask

    initial begin
        int unsigned g;
        rst_v = 1'b0; raw_v = '1; oe_v = '0; out_v = '0; ren_v = '0; fen_v = '0; clr_v = '0;
        reset_n = 1'b0; gpio_raw = raw_v; gpio_oe = oe_v; gpio_output = out_v;
        rise_enable = ren_v; fall_enable = fen_v; pending_clear = clr_v;
        model_reset();

        // Reset with pads high: nothing propagates.
        step(5);
        check("reset_input", gpio_input, 3'b000);
        check("reset_pending", pending, 3'b000);

        // Clean rise on pin 0: 2 sync cycles plus 3 ticks of 4 cycles -> visible after 12 edges.
        raw_v = 3'b001; ren_v = 3'b001;
        step(3);
        rst_v = 1'b1;
        step(1);
        step(11);
        check("rise_not_yet", gpio_input, 3'b000);
        step(1);
        check("rise_input", gpio_input, 3'b001);
        check("rise_pending_lag", pending, 3'b000);
        step(1);
        check("rise_pending", pending, 3'b001);
        check("rise_irq", {2'b00, irq}, 3'b001);

        // Clear racing a fall event on pin 0: the event wins.
        fen_v = 3'b001; raw_v = 3'b000;
        g = 0;
        while (!m_fall[0] && g < 200) begin step(1); g++; end
        if (g >= 200) begin
            n_cmp++; n_bad++;
            $display("FAIL fall_wait: no fall after %0d cycles, required within 200", g);
        end
        clr_v = 3'b001; step(1); clr_v = '0;
        step(1);
        check("race_pending", pending, 3'b001);
        clr_v = 3'b001; step(1); clr_v = '0;
        step(1);
        check("clear_pending", pending, 3'b000);
        check("clear_irq", {2'b00, irq}, 3'b000);

        // Glitch on pin 1 lasting two ticks is discarded.
        ren_v = '1; fen_v = '1;
        raw_v = 3'b010; step(8);
        raw_v = 3'b000; step(40);
        check("glitch_input", gpio_input, 3'b000);
        check("glitch_pending", pending, 3'b000);

        // Output loopback on pin 2, filtering continues underneath.
        oe_v = 3'b100;
        for (int i = 0; i < 6; i++) begin out_v[2] = ~out_v[2]; step(1); end
        raw_v = 3'b100; step(30);
        out_v = '0; step(1);
        check("loop_input", gpio_input, 3'b000);
        oe_v = '0; step(20);
        check("loop_settled", gpio_input, 3'b100);
        check("loop_pending", pending, 3'b000);

        // Reset in the middle of a rise on pin 1.
        rst_v = 1'b0; raw_v = 3'b010; step(2);
        rst_v = 1'b1; step(1);
        step(8);
        rst_v = 1'b0; step(2);
        check("midreset_input", gpio_input, 3'b000);
        rst_v = 1'b1; step(1);
        step(11);
        check("midreset_not_yet", gpio_input, 3'b000);
        step(1);
        check("midreset_input_rise", gpio_input, 3'b010);
        step(1);
        check("midreset_pending", pending, 3'b010);

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < W; i++)
                if ($urandom_range(23) == 0) raw_v[i] = ~raw_v[i];
            if ($urandom_range(99) == 0) oe_v = W'($urandom);
            out_v = W'($urandom);
            if ($urandom_range(199) == 0) begin ren_v = W'($urandom); fen_v = W'($urandom); end
            clr_v = ($urandom_range(15) == 0) ? W'($urandom) : '0;
            rst_v = ($urandom_range(1499) != 0);
            step(1);
        end
        rst_v = 1'b1; clr_v = '0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
